jesd204b_rx_link_ctrl: RTL and testbench

JESD204B_RX_LINK_CTRL -- requirements
Module: jesd204b_rx_link_ctrl

---
 rtl/jesd204b_rx_link_ctrl.sv | 172 +++++++++++++++++
 tb/tb_jesd204b_rx_link_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_rx_link_ctrl.sv
// jesd204b_rx_link_ctrl
//
// Receive-side JESD204B link controller. It brings the link up in three
// steps. In CGS it waits until every lane has seen K_CNT consecutive /K/
// characters. In ILAS it waits until every lane has delivered ILAS_MF /A/
// multiframe markers, and gives up after TIMEOUT cycles. In DATA it keeps
// watching for /K/ runs, which mean the transmitter has lost sync.
//
// Ports:
//   clk        - single clock; all state changes happen on its rising edge
//   reset_n    - asynchronous active-low reset
//   lane_data  - one decoded octet per lane; lane n is bits [8n+7:8n]
//   lane_isk   - per-lane control-character flag
//   sync_n     - SYNC~ to the transmitter; low requests code-group sync
//   link_up    - high in DATA; enables the transport-layer datapath
//   state      - current state: 0=CGS, 1=ILAS, 2=DATA
//   resync_cnt - count of fallbacks to CGS, saturating at 255

module jesd204b_rx_link_ctrl #(
    parameter int LANES   = 4,
    parameter int K_CNT   = 4,
    parameter int ILAS_MF = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [8*LANES-1:0]   lane_data,
    input  logic [LANES-1:0]     lane_isk,
    output logic                 sync_n,
    output logic                 link_up,
    output logic [1:0]           state,
    output logic [7:0]           resync_cnt
);

    localparam int KW = $clog2(K_CNT + 1);
    localparam int AW = $clog2(ILAS_MF + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } linkState_e;

    linkState_e                  state_q, state_d;
    logic [LANES-1:0][KW-1:0]    kCnt_q, kCnt_d;
    logic [LANES-1:0][AW-1:0]    aCnt_q, aCnt_d;
    logic [TW-1:0]               tmoCnt_q, tmoCnt_d;
    logic [7:0]                  resync_q, resync_d;
    logic                        syncN_q, linkUp_q;

    // Per-lane counter values for this cycle, including the octet being
    // sampled now. The state decision uses these values, so the state moves
    // on the same edge that samples the qualifying octet.
    logic [LANES-1:0][KW-1:0]    kInc;
    logic [LANES-1:0][AW-1:0]    aInc;
    logic                        allK, anyK, allA;
    logic [7:0]                  resyncInc;

    always_comb begin
        kInc = '0;
        aInc = '0;
        allK = 1'b1;
        anyK = 1'b0;
        allA = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            // Any octet other than /K/, including /R/ and /A/, breaks the
            // /K/ run on that lane.
            if (lane_isk[i] && lane_data[8*i +: 8] == 8'hBC) begin
                kInc[i] = (kCnt_q[i] == KW'(K_CNT)) ? kCnt_q[i] : kCnt_q[i] + KW'(1);
            end else begin
                kInc[i] = '0;
            end
            if (lane_isk[i] && lane_data[8*i +: 8] == 8'h7C) begin
                aInc[i] = (aCnt_q[i] == AW'(ILAS_MF)) ? aCnt_q[i] : aCnt_q[i] + AW'(1);
            end else begin
                aInc[i] = aCnt_q[i];
            end
            if (kInc[i] != KW'(K_CNT)) allK = 1'b0;
            if (kInc[i] == KW'(K_CNT)) anyK = 1'b1;
            if (aInc[i] != AW'(ILAS_MF)) allA = 1'b0;
        end
        resyncInc = (resync_q == 8'hFF) ? resync_q : resync_q + 8'd1;
    end

    // Next-state logic. Every state change clears all per-lane counters and
    // the timeout counter, so each state starts counting from zero. This also
    // stops saturated K counters from being carried back into CGS.
    always_comb begin
        state_d  = state_q;
        kCnt_d   = kCnt_q;
        aCnt_d   = aCnt_q;
        tmoCnt_d = tmoCnt_q;
        resync_d = resync_q;
        case (state_q)
            ST_CGS: begin
                kCnt_d = kInc;
                if (allK) begin
                    state_d  = ST_ILAS;
                    kCnt_d   = '0;
                    aCnt_d   = '0;
                    tmoCnt_d = '0;
                end
            end
            ST_ILAS: begin
                aCnt_d   = aInc;
                tmoCnt_d = tmoCnt_q + TW'(1);
                // If completion and timeout happen in the same cycle,
                // completion wins.
                if (allA) begin
                    state_d  = ST_DATA;
                    kCnt_d   = '0;
                    aCnt_d   = '0;
                    tmoCnt_d = '0;
                end else if (tmoCnt_q == TW'(TIMEOUT - 1)) begin
                    state_d  = ST_CGS;
                    resync_d = resyncInc;
                    kCnt_d   = '0;
                    aCnt_d   = '0;
                    tmoCnt_d = '0;
                end
            end
            ST_DATA: begin
                // /A/ octets are legal here; only a /K/ run means lost sync.
                kCnt_d = kInc;
                if (anyK) begin
                    state_d  = ST_CGS;
                    resync_d = resyncInc;
                    kCnt_d   = '0;
                    aCnt_d   = '0;
                    tmoCnt_d = '0;
                end
            end
            default: begin
                // Encoding 3 is unreachable; recover quietly without
                // counting it as a resync.
                state_d  = ST_CGS;
                kCnt_d   = '0;
                aCnt_d   = '0;
                tmoCnt_d = '0;
            end
        endcase
    end

    // State register. sync_n and link_up are registered from the next state,
    // so they switch on the same edge as the state itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_CGS;
            kCnt_q   <= '0;
            aCnt_q   <= '0;
            tmoCnt_q <= '0;
            resync_q <= '0;
            syncN_q  <= 1'b0;
            linkUp_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            kCnt_q   <= kCnt_d;
            aCnt_q   <= aCnt_d;
            tmoCnt_q <= tmoCnt_d;
            resync_q <= resync_d;
            syncN_q  <= (state_d != ST_CGS);
            linkUp_q <= (state_d == ST_DATA);
        end
    end

    assign state      = state_q;
    assign sync_n     = syncN_q;
    assign link_up    = linkUp_q;
    assign resync_cnt = resync_q;

endmodule

// File: tb/tb_jesd204b_rx_link_ctrl.sv
// Directed testbench for jesd204b_rx_link_ctrl with the default parameters
// (4 lanes, K_CNT=4, ILAS_MF=4, TIMEOUT=1024).
module tb_jesd204b_rx_link_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic [31:0] laneData;
    logic [3:0]  laneIsk;
    logic        syncN;
    logic        linkUp;
    logic [1:0]  stateO;
    logic [7:0]  resyncCnt;

    int testCount = 0;
    int failCount = 0;

    jesd204b_rx_link_ctrl #(
        .LANES(4), .K_CNT(4), .ILAS_MF(4), .TIMEOUT(1024)
    ) dut (
        .clk(clk),
        .reset_n(resetN),
        .lane_data(laneData),
        .lane_isk(laneIsk),
        .sync_n(syncN),
        .link_up(linkUp),
        .state(stateO),
        .resync_cnt(resyncCnt)
    );

    always #5 clk = ~clk;

    // Advances one rising edge and leaves the bench 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveAll(input logic [7:0] d, input logic k);
        for (int i = 0; i < 4; i++) begin
            laneData[8*i +: 8] = d;
            laneIsk[i] = k;
        end
    endtask

    task automatic driveLane(input int n, input logic [7:0] d, input logic k);
        laneData[8*n +: 8] = d;
        laneIsk[n] = k;
    endtask

    task automatic doReset();
        resetN = 1'b0;
        driveAll(8'h00, 1'b0);
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        driveAll(8'h00, 1'b0);
        #3;
        testCount++;
        if (stateO !== 2'd0) begin failCount++; $display("[TB] FAIL reset_state: got %0d expected 0", stateO); end
        testCount++;
        if (syncN !== 1'b0) begin failCount++; $display("[TB] FAIL reset_sync_n: got %b expected 0", syncN); end
        testCount++;
        if (linkUp !== 1'b0) begin failCount++; $display("[TB] FAIL reset_link_up: got %b expected 0", linkUp); end
        testCount++;
        if (resyncCnt !== 8'd0) begin failCount++; $display("[TB] FAIL reset_resync: got %0d expected 0", resyncCnt); end
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic test_sync();
        driveAll(8'hBC, 1'b1);
        tick(); tick(); tick();
        testCount++;
        if (stateO !== 2'd0) begin failCount++; $display("[TB] FAIL sync_after3: got %0d expected 0", stateO); end
        tick();
        testCount++;
        if (stateO !== 2'd1) begin failCount++; $display("[TB] FAIL sync_state: got %0d expected 1", stateO); end
        testCount++;
        if (syncN !== 1'b1) begin failCount++; $display("[TB] FAIL sync_sync_n: got %b expected 1", syncN); end
        testCount++;
        if (linkUp !== 1'b0) begin failCount++; $display("[TB] FAIL sync_link_up: got %b expected 0", linkUp); end
        testCount++;
        if (resyncCnt !== 8'd0) begin failCount++; $display("[TB] FAIL sync_resync: got %0d expected 0", resyncCnt); end
    endtask

    task automatic test_cgs_glitch();
        doReset();
        driveAll(8'hBC, 1'b1);
        tick(); tick();
        driveLane(2, 8'h00, 1'b0);
        tick();
        driveAll(8'hBC, 1'b1);
        tick();
        testCount++;
        if (stateO !== 2'd0) begin failCount++; $display("[TB] FAIL glitch_after4: got %0d expected 0", stateO); end
        tick(); tick();
        testCount++;
        if (stateO !== 2'd0) begin failCount++; $display("[TB] FAIL glitch_after3more: got %0d expected 0", stateO); end
        tick();
        testCount++;
        if (stateO !== 2'd1) begin failCount++; $display("[TB] FAIL glitch_sync: got %0d expected 1", stateO); end
    endtask

    // Multiframes of 32 octets: /R/ first, /A/ last, filler between.
    // Lane 3 runs 2 cycles behind the others.
    task automatic test_ilas_complete();
        int p;
        for (int c = 0; c < 130; c++) begin
            for (int n = 0; n < 4; n++) begin
                p = (n == 3) ? c - 2 : c;
                if (p < 0)            driveLane(n, 8'h00, 1'b0);
                else if (p % 32 == 0) driveLane(n, 8'h1C, 1'b1);
                else if (p % 32 == 31) driveLane(n, 8'h7C, 1'b1);
                else                  driveLane(n, 8'h5A, 1'b0);
            end
            tick();
            if (c == 127 || c == 128) begin
                testCount++;
                if (stateO !== 2'd1 || linkUp !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL ilas_early_c%0d: got state=%0d link_up=%b expected state=1 link_up=0", c, stateO, linkUp);
                end
            end
        end
        testCount++;
        if (stateO !== 2'd2) begin failCount++; $display("[TB] FAIL ilas_state: got %0d expected 2", stateO); end
        testCount++;
        if (linkUp !== 1'b1) begin failCount++; $display("[TB] FAIL ilas_link_up: got %b expected 1", linkUp); end
        testCount++;
        if (syncN !== 1'b1) begin failCount++; $display("[TB] FAIL ilas_sync_n: got %b expected 1", syncN); end
        // /A/ in DATA is harmless
        driveAll(8'h7C, 1'b1);
        tick(); tick(); tick(); tick(); tick();
        testCount++;
        if (stateO !== 2'd2) begin failCount++; $display("[TB] FAIL data_a_ignored: got %0d expected 2", stateO); end
    endtask

    task automatic test_loss_of_sync();
        driveAll(8'h55, 1'b0);
        driveLane(0, 8'hBC, 1'b1);
        tick(); tick(); tick();
        driveLane(0, 8'h55, 1'b0);
        tick();
        testCount++;
        if (stateO !== 2'd2) begin failCount++; $display("[TB] FAIL los_3k_stay: got %0d expected 2", stateO); end
        driveLane(0, 8'hBC, 1'b1);
        tick(); tick(); tick();
        testCount++;
        if (stateO !== 2'd2) begin failCount++; $display("[TB] FAIL los_before4: got %0d expected 2", stateO); end
        tick();
        testCount++;
        if (stateO !== 2'd0) begin failCount++; $display("[TB] FAIL los_state: got %0d expected 0", stateO); end
        testCount++;
        if (resyncCnt !== 8'd1) begin failCount++; $display("[TB] FAIL los_resync: got %0d expected 1", resyncCnt); end
        testCount++;
        if (syncN !== 1'b0 || linkUp !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL los_outputs: got sync_n=%b link_up=%b expected 0/0", syncN, linkUp);
        end
    endtask

    task automatic test_timeout();
        doReset();
        driveAll(8'hBC, 1'b1);
        repeat (4) tick();
        testCount++;
        if (stateO !== 2'd1) begin failCount++; $display("[TB] FAIL tmo_enter: got %0d expected 1", stateO); end
        driveAll(8'h55, 1'b0);
        repeat (1023) tick();
        testCount++;
        if (stateO !== 2'd1) begin failCount++; $display("[TB] FAIL tmo_before: got %0d expected 1", stateO); end
        tick();
        testCount++;
        if (stateO !== 2'd0) begin failCount++; $display("[TB] FAIL tmo_state: got %0d expected 0", stateO); end
        testCount++;
        if (syncN !== 1'b0) begin failCount++; $display("[TB] FAIL tmo_sync_n: got %b expected 0", syncN); end
        testCount++;
        if (resyncCnt !== 8'd1) begin failCount++; $display("[TB] FAIL tmo_resync: got %0d expected 1", resyncCnt); end
    endtask

    // The fourth /A/ arrives on the same cycle the timeout expires.
    task automatic test_complete_vs_timeout();
        driveAll(8'hBC, 1'b1);
        repeat (4) tick();
        driveAll(8'h55, 1'b0);
        repeat (1020) tick();
        driveAll(8'h7C, 1'b1);
        repeat (3) tick();
        testCount++;
        if (stateO !== 2'd1) begin failCount++; $display("[TB] FAIL tie_before: got %0d expected 1", stateO); end
        tick();
        testCount++;
        if (stateO !== 2'd2) begin failCount++; $display("[TB] FAIL tie_state: got %0d expected 2", stateO); end
        testCount++;
        if (resyncCnt !== 8'd1) begin failCount++; $display("[TB] FAIL tie_resync: got %0d expected 1", resyncCnt); end
        driveAll(8'h55, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_data();
        #3;
        resetN = 1'b0;
        #1;
        testCount++;
        if (linkUp !== 1'b0) begin failCount++; $display("[TB] FAIL rst_data_link_up: got %b expected 0", linkUp); end
        testCount++;
        if (syncN !== 1'b0) begin failCount++; $display("[TB] FAIL rst_data_sync_n: got %b expected 0", syncN); end
        testCount++;
        if (stateO !== 2'd0) begin failCount++; $display("[TB] FAIL rst_data_state: got %0d expected 0", stateO); end
        testCount++;
        if (resyncCnt !== 8'd0) begin failCount++; $display("[TB] FAIL rst_data_resync: got %0d expected 0", resyncCnt); end
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0;
        laneData = '0;
        laneIsk = '0;
        test_reset();
        test_sync();
        test_cgs_glitch();
        test_ilas_complete();
        test_loss_of_sync();
        test_timeout();
        test_complete_vs_timeout();
        test_reset_mid_data();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
